// File: rtl/vram_arbiter.sv
// Two-requester arbiter for the single-port tile/video RAM: video owns active display,
// CPU owns blanking plus a forced slot after STARVE_MAX denials. Optional stats: VRAM_ARB_STATS_EN.
module vram_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 8,
    parameter int STARVE_MAX = 15
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_blank,
    input  logic              i_vid_req,
    input  logic [ADDR_W-1:0] i_vid_addr,
    output logic              o_vid_gnt,
    output logic              o_vid_rvalid,
    output logic [DATA_W-1:0] o_vid_rdata,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic              o_cpu_gnt,
    output logic              o_cpu_rvalid,
    output logic [DATA_W-1:0] o_cpu_rdata,
    output logic              o_ram_en,
    output logic              o_ram_we,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_wdata,
    input  logic [DATA_W-1:0] i_ram_rdata,
    output logic [15:0]       o_stall_cnt
);

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    typedef enum logic {ST_NORMAL, ST_FORCE} state_t;

    state_t            r_state, w_state_next;
    logic [7:0]        r_starve_cnt, w_starve_next;
    logic              w_vid_gnt, w_cpu_gnt;
    logic              r_owner_cpu, r_rd_pend;
    logic [DATA_W-1:0] r_vid_rdata, r_cpu_rdata;

    // Grants are gated by reset so nothing reaches the RAM while rst_n is low.
    always_comb begin
        w_vid_gnt = 1'b0;
        w_cpu_gnt = 1'b0;
        if (i_rst_n) begin
            if (r_state == ST_FORCE) begin
                w_cpu_gnt = i_cpu_req;
            end else if (i_blank) begin
                w_cpu_gnt = i_cpu_req;
                w_vid_gnt = i_vid_req & ~i_cpu_req;
            end else begin
                w_vid_gnt = i_vid_req;
                w_cpu_gnt = i_cpu_req & ~i_vid_req;
            end
        end
    end

    always_comb begin
        w_starve_next = r_starve_cnt;
        w_state_next  = ST_NORMAL;
        if (!i_cpu_req || w_cpu_gnt)
            w_starve_next = 8'd0;
        else if (r_starve_cnt >= STARVE_LIM)
            w_starve_next = STARVE_LIM;
        else
            w_starve_next = r_starve_cnt + 8'd1;
        // A FORCE slot lasts one cycle; the counter always clears during it.
        if (r_state == ST_NORMAL && w_starve_next == STARVE_LIM)
            w_state_next = ST_FORCE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_NORMAL;
            r_starve_cnt <= 8'd0;
            r_owner_cpu  <= 1'b0;
            r_rd_pend    <= 1'b0;
            r_vid_rdata  <= '0;
            r_cpu_rdata  <= '0;
        end else begin
            r_state      <= w_state_next;
            r_starve_cnt <= w_starve_next;
            r_owner_cpu  <= w_cpu_gnt;
            r_rd_pend    <= w_vid_gnt | (w_cpu_gnt & ~i_cpu_we);
            if (o_vid_rvalid)
                r_vid_rdata <= i_ram_rdata;
            if (o_cpu_rvalid)
                r_cpu_rdata <= i_ram_rdata;
        end
    end

    assign o_vid_gnt    = w_vid_gnt;
    assign o_cpu_gnt    = w_cpu_gnt;
    assign o_vid_rvalid = r_rd_pend & ~r_owner_cpu;
    assign o_cpu_rvalid = r_rd_pend & r_owner_cpu;
    assign o_vid_rdata  = o_vid_rvalid ? i_ram_rdata : r_vid_rdata;
    assign o_cpu_rdata  = o_cpu_rvalid ? i_ram_rdata : r_cpu_rdata;

    assign o_ram_en    = w_vid_gnt | w_cpu_gnt;
    assign o_ram_we    = w_cpu_gnt & i_cpu_we;
    assign o_ram_addr  = w_cpu_gnt ? i_cpu_addr : i_vid_addr;
    assign o_ram_wdata = i_cpu_wdata;

`ifdef VRAM_ARB_STATS_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_stall_cnt <= 16'h0000;
        else if (i_cpu_req && !w_cpu_gnt && r_stall_cnt != 16'hFFFF)
            r_stall_cnt <= r_stall_cnt + 16'h0001;
    end

    assign o_stall_cnt = r_stall_cnt;
`else
    assign o_stall_cnt = 16'h0000;
`endif

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port synchronous tile/video RAM (1 KiB, 8-bit) between two requesters: the tilemap fetch engine (video) and the CPU/loader port.
- Video owns the RAM during active display. The CPU gets the RAM during blanking and through a bounded anti-starvation slot.
- Sits between full_tile's fetch logic and the VRAM block instance, clocked on the pixel-fetch clock domain.

Parameters:
- ADDR_W, 10, RAM address width (1024 entries)
- DATA_W, 8, RAM data width
- STARVE_MAX, 15, consecutive denied CPU cycles before a forced CPU slot; legal range 1..255

Ports:
- clk  in  1  fetch clock, rising edge
- rst  in  1  asynchronous active-low reset
- blank  in  1  display blanking from vga_ctrl; 1 = blanking
- vid_req  in  1  video read request
- vid_addr  in  ADDR_W  video read address
- vid_gnt  out  1  video request accepted this cycle
- vid_rvalid  out  1  vid_rdata valid (one cycle after vid_gnt)
- vid_rdata  out  DATA_W  video read data
- cpu_req  in  1  CPU request; addr/we/wdata held stable until cpu_gnt
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  CPU request accepted this cycle
- cpu_rvalid  out  1  cpu_rdata valid (one cycle after a read grant)
- cpu_rdata  out  DATA_W  CPU read data
- ram_en  out  1  RAM enable
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid 1 cycle after ram_en with ram_we=0
- stall_cnt  out  16  CPU stall statistics (see Optional Feature)

Behaviour:
- Grant logic is combinational from registered state and current requests. At most one of vid_gnt/cpu_gnt is high per cycle. The RAM port is driven combinationally from the winner; ram_en=0 when there is no grant.
- State register, two states:
  - NORMAL:
    - blank=1: CPU wins if cpu_req, else video.
    - blank=0: video wins if vid_req, else CPU.
  - FORCE: CPU wins if cpu_req, regardless of blank and vid_req.
  - NORMAL->FORCE when starve_cnt reaches STARVE_MAX on the clock edge.
  - FORCE->NORMAL after exactly one cycle, whether or not the CPU was granted (if cpu_req dropped, no grant is issued that cycle).
- starve_cnt (8-bit):
  - +1 on each cycle with cpu_req=1 and cpu_gnt=0, saturating at STARVE_MAX.
  - Cleared on cpu_gnt or when cpu_req=0.
- A denied video request gets vid_gnt=0. The fetch engine holds vid_req/vid_addr until granted.
- Read return path:
  - A 1-bit owner register plus a read flag capture the granted requester and !we.
  - Next cycle, the matching rvalid pulses for 1 cycle and the rdata output is ram_rdata.
  - The non-owner rvalid stays 0; rdata outputs hold their last value when not valid.
  - CPU writes produce no cpu_rvalid.
- Back-to-back grants are allowed every cycle. Throughput is 1 access/cycle and read latency is exactly 1 cycle after gnt.
- Write-then-read to the same address on consecutive cycles returns the new data (RAM is write-first; the arbiter adds no bypass).
- Reset (rst=0, async):
  - state=NORMAL, starve_cnt=0, owner/read flag=0.
  - All gnt/rvalid outputs 0; rdata outputs 0; stall_cnt 0; ram_en/ram_we 0.
  - Reset mid-read suppresses the pending rvalid.
- Requesters must not change address while req=1 and gnt=0. The arbiter does not check this.

Optional Feature:
- Macro VRAM_ARB_STATS_EN.
- Defined: stall_cnt is a 16-bit counter.
  - +1 each cycle cpu_req=1 and cpu_gnt=0.
  - Saturates at 16'hFFFF.
  - Cleared only by reset.
- Undefined: no counter logic; stall_cnt is tied to 16'h0000.

Test Plan:
- Reset: rst=0 while cpu_req=1 and vid_req=1 -> all gnt/rvalid 0 and ram_en=0; after release in active video, vid_gnt=1 on the first cycle.
- Blanking priority: blank=1, both req, cpu_we=1, cpu_addr=10'h3A5, cpu_wdata=8'h5C -> cpu_gnt=1, ram_we=1, ram_addr=3A5, vid_gnt=0; next cycle, CPU read of 3A5 -> cpu_rvalid=1, cpu_rdata=8'h5C one cycle after grant.
- Active video: blank=0, vid_req held high, vid_addr increments 0..7 -> vid_gnt every cycle; vid_rvalid follows each grant by one cycle with matching RAM data; cpu_req=0 -> cpu_gnt never asserts.
- Starvation: blank=0, vid_req=1 continuously, cpu_req=1 (read 10'h010) -> cpu_gnt first asserts on cycle 16 after request (STARVE_MAX=15); vid_gnt=0 that cycle only; starve_cnt returns to 0.
- Forced slot with request withdrawn: counter at STARVE_MAX, then cpu_req drops -> FORCE cycle issues no grant; ram_en=0 unless in NORMAL the next cycle; video resumes the following cycle.
- Stats (VRAM_ARB_STATS_EN): 15 denied cycles, grant, then 3 more denied cycles -> stall_cnt=18. Without the macro -> stall_cnt=0 throughout.
